// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU data port (C) and the DMA/debug port (D).
// Round-robin on in-range contention; out-of-range requests are answered with an error pulse.
module dm_port_arbiter #(
  parameter logic [31:0] DM_START = 32'h0000_0000,
  parameter logic [31:0] DM_END   = 32'h0000_2fff
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        cpu_stall,

  output logic        dm_en,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {PortC = 1'b0, PortD = 1'b1} port_e;

  port_e last_gnt_q;
  logic  c_rvalid_q, d_rvalid_q;
  logic  c_err_q, d_err_q;

  logic  c_in, d_in;
  logic  c_dm_req, d_dm_req;
  logic  c_oor_req, d_oor_req;
  logic  c_dm_gnt, d_dm_gnt;

  // 33-bit differences keep the bounds check unsigned without comparing against a constant zero.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] lo_diff;
    logic [32:0] hi_diff;
    lo_diff = {1'b0, addr} - {1'b0, DM_START};
    hi_diff = {1'b0, DM_END} - {1'b0, addr};
    return ~lo_diff[32] & ~hi_diff[32];
  endfunction

  assign c_in      = in_range(c_addr);
  assign d_in      = in_range(d_addr);
  assign c_dm_req  = c_req & c_in;
  assign d_dm_req  = d_req & d_in;
  assign c_oor_req = c_req & ~c_in;
  assign d_oor_req = d_req & ~d_in;

  always_comb begin
    c_dm_gnt = 1'b0;
    d_dm_gnt = 1'b0;
    if (c_dm_req && d_dm_req) begin
      if (last_gnt_q == PortD) begin
        c_dm_gnt = 1'b1;
      end else begin
        d_dm_gnt = 1'b1;
      end
    end else begin
      c_dm_gnt = c_dm_req;
      d_dm_gnt = d_dm_req;
    end
  end

  // Out-of-range requests never compete for DM, so they are accepted immediately.
  assign c_gnt     = c_oor_req | c_dm_gnt;
  assign d_gnt     = d_oor_req | d_dm_gnt;
  assign cpu_stall = c_req & ~c_gnt;

  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 4'b0000;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    if (c_dm_gnt) begin
      dm_en    = 1'b1;
      dm_we    = c_we ? c_be : 4'b0000;
      dm_addr  = c_addr;
      dm_wdata = c_wdata;
    end else if (d_dm_gnt) begin
      dm_en    = 1'b1;
      dm_we    = d_we ? d_be : 4'b0000;
      dm_addr  = d_addr;
      dm_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PortD;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      c_rvalid_q <= c_dm_gnt & ~c_we;
      d_rvalid_q <= d_dm_gnt & ~d_we;
      c_err_q    <= c_oor_req;
      d_err_q    <= d_oor_req;
      if (c_dm_gnt) begin
        last_gnt_q <= PortC;
      end else if (d_dm_gnt) begin
        last_gnt_q <= PortD;
      end
    end
  end

  // A response landing in a reset cycle is dropped rather than presented.
  assign c_rvalid = c_rvalid_q & ~reset;
  assign d_rvalid = d_rvalid_q & ~reset;
  assign c_err    = c_err_q & ~reset;
  assign d_err    = d_err_q & ~reset;
  assign c_rdata  = c_rvalid ? dm_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? dm_rdata : 32'h0;

endmodule
